// File: rtl/hart_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : hart_sched_if
//  Purpose  : Issue-slot handshake toward fetch plus retire feedback from regwr.
//  Revision : 1.0
// ============================================================================
interface hart_sched_if #(
    parameter int NUM_HART = 4
);
    localparam int HART_IDX_W = $clog2(NUM_HART);

    logic                  issue_valid;
    logic                  issue_ready;
    logic [NUM_HART-1:0]   issue_hart_sel;
    logic [HART_IDX_W-1:0] issue_hart_idx;
    logic                  retire_valid;
    logic [NUM_HART-1:0]   retire_hart_sel;

    modport master (
        output issue_valid,
        output issue_hart_sel,
        output issue_hart_idx,
        input  issue_ready,
        input  retire_valid,
        input  retire_hart_sel
    );

    modport slave (
        input  issue_valid,
        input  issue_hart_sel,
        input  issue_hart_idx,
        output issue_ready,
        output retire_valid,
        output retire_hart_sel
    );
endinterface
`default_nettype wire

// File: rtl/hart_sched.sv
`default_nettype none
// ============================================================================
//  Module   : hart_sched
//  Purpose  : Barrel-hart issue scheduler with per-hart enable, in-flight
//             tracking, re-issue cooldown and strict/skip arbitration.
//  Revision : 1.0
// ============================================================================
module hart_sched #(
    parameter int NUM_HART   = 4,
    parameter int PIPE_DEPTH = 5,
    parameter int SKIP_MODE  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_HART-1:0] hart_en,
    hart_sched_if.master        bus,
    output logic [NUM_HART-1:0] hart_quiesced,
    output logic                idle
);

    localparam int HART_IDX_W = $clog2(NUM_HART);
    localparam int COOL_W     = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    localparam logic [COOL_W-1:0]     c_cool_load = COOL_W'((PIPE_DEPTH > 1) ? PIPE_DEPTH - 1 : 0);
    localparam logic [COOL_W-1:0]     c_cool_one  = COOL_W'(1);
    localparam logic [HART_IDX_W-1:0] c_last_hart = HART_IDX_W'(NUM_HART - 1);

    logic                  r_valid;
    logic [NUM_HART-1:0]   r_sel;
    logic [HART_IDX_W-1:0] r_idx;
    logic [HART_IDX_W-1:0] r_ptr;
    logic [NUM_HART-1:0]   r_inflight;
    logic [COOL_W-1:0]     r_cool [NUM_HART];

    logic                  w_accept;
    logic                  w_hold;
    logic [NUM_HART-1:0]   w_accept_mask;
    logic [NUM_HART-1:0]   w_retire_mask;
    logic [NUM_HART-1:0]   w_cool_done;
    logic [NUM_HART-1:0]   w_slot_busy;
    logic [NUM_HART-1:0]   w_elig;
    logic                  w_next_valid;
    logic [HART_IDX_W-1:0] w_next_idx;
    logic [HART_IDX_W-1:0] w_next_ptr;
    logic [NUM_HART-1:0]   w_next_sel;

    function automatic logic [HART_IDX_W-1:0] f_next_ptr(input logic [HART_IDX_W-1:0] p);
        f_next_ptr = (p == c_last_hart) ? '0 : p + 1'b1;
    endfunction

    assign w_accept      = r_valid & bus.issue_ready;
    assign w_hold        = r_valid & ~bus.issue_ready;
    assign w_accept_mask = w_accept ? r_sel : '0;
    assign w_retire_mask = bus.retire_valid ? bus.retire_hart_sel : '0;

    // A count of 1 is already expired: the slot chosen at this edge is only
    // accepted one edge later, which lands exactly PIPE_DEPTH after the last accept.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_HART; gi++) begin : g_hart
            assign w_cool_done[gi]   = (r_cool[gi] <= c_cool_one);
            assign w_slot_busy[gi]   = r_valid & r_sel[gi];
            assign w_elig[gi]        = hart_en[gi] & ~r_inflight[gi] & w_cool_done[gi] & ~w_slot_busy[gi];
            assign hart_quiesced[gi] = ~r_inflight[gi] & w_cool_done[gi] & ~w_slot_busy[gi];
        end
    endgenerate

    generate
        if (SKIP_MODE != 0) begin : g_skip
            logic                  w_found;
            logic [HART_IDX_W-1:0] w_cand;
            logic [HART_IDX_W-1:0] w_win;

            always_comb begin
                w_found = 1'b0;
                w_cand  = r_ptr;
                w_win   = '0;
                for (int k = 0; k < NUM_HART; k++) begin
                    if (!w_found && w_elig[w_cand]) begin
                        w_found = 1'b1;
                        w_win   = w_cand;
                    end
                    w_cand = f_next_ptr(w_cand);
                end
            end

            assign w_next_valid = w_found;
            assign w_next_idx   = w_found ? w_win : '0;
            assign w_next_ptr   = w_found ? f_next_ptr(w_win) : r_ptr;
        end else begin : g_strict
            // Fixed rotation: an ineligible owner of the slot leaves a bubble.
            assign w_next_valid = w_elig[r_ptr];
            assign w_next_idx   = w_elig[r_ptr] ? r_ptr : '0;
            assign w_next_ptr   = f_next_ptr(r_ptr);
        end
    endgenerate

    always_comb begin
        w_next_sel = '0;
        if (w_next_valid) begin
            w_next_sel[w_next_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else if (!w_hold) begin
            r_valid <= w_next_valid;
            r_sel   <= w_next_sel;
            r_idx   <= w_next_idx;
            r_ptr   <= w_next_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= (r_inflight & ~w_retire_mask) | w_accept_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_HART; i++) begin
                r_cool[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_HART; i++) begin
                if (w_accept_mask[i]) begin
                    r_cool[i] <= c_cool_load;
                end else if (r_cool[i] != '0) begin
                    r_cool[i] <= r_cool[i] - 1'b1;
                end
            end
        end
    end

    assign bus.issue_valid    = r_valid;
    assign bus.issue_hart_sel = r_sel;
    assign bus.issue_hart_idx = r_idx;
    assign idle               = ~r_valid & ~|r_inflight & ~|hart_en;

endmodule
`default_nettype wire

// File: tb/tb_hart_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hart_sched
//  Purpose  : Scoreboard bench for hart_sched across skip/strict and depth variants.
//  Revision : 1.0
// ============================================================================
module tb_hart_sched;

    typedef struct {
        int dut;
        int idx;
        int off;
    } item_t;

    typedef struct {
        int         dut;
        logic [3:0] sel;
        int         due;
    } ret_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            rdy;
    logic [2:0][3:0] en;
    logic [2:0]      v;
    logic [2:0][3:0] sel;
    logic [2:0][1:0] idx;
    logic [2:0][3:0] q;
    logic [2:0]      idl;
    logic [2:0]      arv;
    logic [2:0][3:0] arsel;
    logic            mrv;
    logic [3:0]      msel;

    int    cyc = 0;
    int    base = 0;
    int    ret_dly = 2;
    logic [3:0] withhold = 4'b0000;
    int    n_chk = 0;
    int    n_fail = 0;
    item_t exp_q[$];
    ret_t  ret_q[$];

    hart_sched_if #(.NUM_HART(4)) bus0 ();
    hart_sched_if #(.NUM_HART(4)) bus1 ();
    hart_sched_if #(.NUM_HART(4)) bus2 ();

    hart_sched #(.NUM_HART(4), .PIPE_DEPTH(4), .SKIP_MODE(1)) dut0 (
        .clk(clk), .rst(rst), .hart_en(en[0]), .bus(bus0.master),
        .hart_quiesced(q[0]), .idle(idl[0]));
    hart_sched #(.NUM_HART(4), .PIPE_DEPTH(4), .SKIP_MODE(0)) dut1 (
        .clk(clk), .rst(rst), .hart_en(en[1]), .bus(bus1.master),
        .hart_quiesced(q[1]), .idle(idl[1]));
    hart_sched #(.NUM_HART(4), .PIPE_DEPTH(5), .SKIP_MODE(1)) dut2 (
        .clk(clk), .rst(rst), .hart_en(en[2]), .bus(bus2.master),
        .hart_quiesced(q[2]), .idle(idl[2]));

    assign bus0.issue_ready     = rdy;
    assign bus1.issue_ready     = rdy;
    assign bus2.issue_ready     = rdy;
    assign bus0.retire_valid    = arv[0] | mrv;
    assign bus0.retire_hart_sel = mrv ? msel : arsel[0];
    assign bus1.retire_valid    = arv[1];
    assign bus1.retire_hart_sel = arsel[1];
    assign bus2.retire_valid    = arv[2];
    assign bus2.retire_hart_sel = arsel[2];

    assign v[0]   = bus0.issue_valid;
    assign v[1]   = bus1.issue_valid;
    assign v[2]   = bus2.issue_valid;
    assign sel[0] = bus0.issue_hart_sel;
    assign sel[1] = bus1.issue_hart_sel;
    assign sel[2] = bus2.issue_hart_sel;
    assign idx[0] = bus0.issue_hart_idx;
    assign idx[1] = bus1.issue_hart_idx;
    assign idx[2] = bus2.issue_hart_idx;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted slot is matched against the scoreboard and
    // schedules the retire pulse that the pipeline would send back.
    always @(negedge clk) begin
        item_t      e;
        logic [3:0] want_sel;
        arv = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (rst && v[k] && rdy) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL issue dut%0d off=%0d: got idx=%0d, required no issue",
                             k, cyc - base, idx[k]);
                end else begin
                    e        = exp_q.pop_front();
                    want_sel = 4'b0001 << e.idx;
                    if (e.dut != k || e.idx != int'(idx[k]) || e.off != cyc - base || sel[k] != want_sel) begin
                        n_fail++;
                        $display("FAIL issue: got dut%0d idx=%0d sel=%b off=%0d, required dut%0d idx=%0d sel=%b off=%0d",
                                 k, idx[k], sel[k], cyc - base, e.dut, e.idx, want_sel, e.off);
                    end
                end
                if (!withhold[idx[k]]) begin
                    ret_q.push_back('{k, sel[k], cyc + ret_dly});
                end
            end
        end
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            arv[ret_q[0].dut]   = 1'b1;
            arsel[ret_q[0].dut] = ret_q[0].sel;
            void'(ret_q.pop_front());
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic expect_issue(input int d, input int i, input int o);
        exp_q.push_back('{d, i, o});
    endtask

    task automatic run_to(input int off);
        while (cyc - base < off) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_phase();
        rst  = 1'b1;
        base = cyc;
    endtask

    task automatic check_drained(input string nm);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d issues still pending, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic end_phase(input string nm);
        rst = 1'b0;
        en  = '0;
        rdy = 1'b1;
        mrv = 1'b0;
        ret_q.delete();
        #1;
        check_drained(nm);
        withhold = 4'b0000;
        ret_dly  = 2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b0;
        rdy  = 1'b1;
        en   = '0;
        mrv  = 1'b0;
        msel = 4'b0000;
        arsel = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_valid%0d", k), int'(v[k]), 0);
            chk($sformatf("reset_sel%0d", k), int'(sel[k]), 0);
            chk($sformatf("reset_quiesced%0d", k), int'(q[k]), 15);
            chk($sformatf("reset_idle%0d", k), int'(idl[k]), 1);
        end

        // Full rotation, no bubbles
        start_phase();
        en[0] = 4'hF;
        for (int o = 1; o <= 12; o++) expect_issue(0, (o - 1) % 4, o);
        run_to(13);
        end_phase("rotation");

        // Skip mode over a sparse enable mask
        start_phase();
        en[0] = 4'b0101;
        expect_issue(0, 0, 1); expect_issue(0, 2, 2);
        expect_issue(0, 0, 5); expect_issue(0, 2, 6);
        run_to(9);
        end_phase("skip_sparse");

        // Strict slots over the same mask
        start_phase();
        en[1] = 4'b0101;
        expect_issue(1, 0, 1); expect_issue(1, 2, 3);
        expect_issue(1, 0, 5); expect_issue(1, 2, 7);
        run_to(9);
        end_phase("strict_sparse");

        // Back-pressure hold while the presented hart is disabled
        start_phase();
        en[0] = 4'b1010;
        rdy   = 1'b0;
        expect_issue(0, 1, 6); expect_issue(0, 3, 7);
        expect_issue(0, 3, 11); expect_issue(0, 3, 15);
        run_to(1);
        chk("hold_sel_first", int'(sel[0]), 2);
        en[0] = 4'b1000;
        for (int o = 2; o <= 6; o++) begin
            run_to(o);
            chk($sformatf("hold_sel_off%0d", o), int'(sel[0]), 2);
            chk($sformatf("hold_valid_off%0d", o), int'(v[0]), 1);
        end
        rdy = 1'b1;
        run_to(16);
        end_phase("hold");

        // Single hart, depth 5, immediate retire
        start_phase();
        ret_dly = 1;
        en[2]   = 4'b0001;
        expect_issue(2, 0, 1); expect_issue(2, 0, 6);
        expect_issue(2, 0, 11); expect_issue(2, 0, 16);
        run_to(3);
        chk("cooldown_quiesced_off3", int'(q[2][0]), 0);
        run_to(5);
        chk("cooldown_quiesced_off5", int'(q[2][0]), 1);
        run_to(17);
        end_phase("cooldown");

        // Withheld retire blocks the hart until a late retire pulse
        start_phase();
        withhold = 4'b0100;
        en[0]    = 4'b0100;
        expect_issue(0, 2, 1); expect_issue(0, 2, 12);
        run_to(10);
        chk("withheld_quiesced", int'(q[0][2]), 0);
        chk("withheld_valid", int'(v[0]), 0);
        mrv  = 1'b1;
        msel = 4'b0100;
        run_to(11);
        mrv  = 1'b0;
        chk("retired_quiesced", int'(q[0][2]), 1);
        run_to(16);
        end_phase("withheld");

        // Asynchronous reset mid-stream
        start_phase();
        en[0] = 4'hF;
        for (int o = 1; o <= 5; o++) expect_issue(0, (o - 1) % 4, o);
        run_to(6);
        rst = 1'b0;
        ret_q.delete();
        #1;
        chk("async_valid", int'(v[0]), 0);
        chk("async_sel", int'(sel[0]), 0);
        chk("async_idx", int'(idx[0]), 0);
        chk("async_quiesced", int'(q[0]), 15);
        chk("async_idle", int'(idl[0]), 0);
        check_drained("pre_reset");
        @(posedge clk);
        #1;
        start_phase();
        expect_issue(0, 0, 1); expect_issue(0, 1, 2); expect_issue(0, 2, 3);
        run_to(4);
        end_phase("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
